cache_miss_sequencer: RTL

CACHE_MISS_SEQUENCER -- requirements
Module: cache_miss_sequencer

---
 rtl/cache_miss_sequencer_pkg.sv | 51 +++++
 rtl/cache_miss_sequencer_sat_counter.sv | 21 ++
 rtl/cache_miss_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_miss_sequencer_pkg.sv
// Shared definitions for the cache miss sequencer: field widths, FSM state
// encoding, the debug snapshot struct and address field helpers.
package cache_miss_sequencer_pkg;

  // Request / memory field widths
  localparam int ADDR_W     = 5;  // tag [4:2], index [1:0]
  localparam int TAG_W      = 3;
  localparam int IDX_W      = 2;
  localparam int DATA_W     = 3;
  localparam int MEM_ADDR_W = 4;

  // Width of the read-latency down-counter (MEM_LAT is at most 4)
  localparam int LAT_W      = 3;

  // Raw state codes, kept as plain constants for legacy tooling that
  // decodes the state bus numerically.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WB   = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_FILL = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // FSM state enumeration built on the raw codes above
  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_WB   = ST_WB,
    S_RD   = ST_RD,
    S_FILL = ST_FILL,
    S_DONE = ST_DONE
  } state_e;

  // Debug snapshot: current state plus the captured miss request
  typedef struct packed {
    state_e              state;
    logic                wren;
    logic                dirty;
    logic [TAG_W-1:0]    victim_tag;
    logic [ADDR_W-1:0]   addr;
  } miss_dbg_t;

  // Tag field of a request address
  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:IDX_W];
  endfunction

  // Index field of a request address
  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/cache_miss_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear. Clear wins over increment,
// so a reset coinciding with an increment leaves the count at zero.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, stick at all-ones, clear synchronously
  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_miss_sequencer.sv
// Cache miss sequencer: accepts one miss at a time from the cache, writes
// back a dirty victim, reads the missing word from main memory, delivers it
// as a one-cycle refill strobe and signals the end of the miss with done.
//
// Handshake: a miss transfers on a rising edge where req_valid=1 and
// req_ready=1. req_ready is high only in IDLE; the request and victim fields
// are captured on that edge and all request inputs are ignored until the
// sequencer is back in IDLE. A requester holding req_valid high through
// DONE is accepted on the first IDLE edge, leaving one idle cycle.
//
// Memory interface: mem_addr/mem_wren/mem_wdata are driven combinationally
// from the state. In RD the read address is held steady for MEM_LAT cycles
// (legal range 1..4) and mem_rdata is sampled on the edge leaving RD.
module cache_miss_sequencer
  import cache_miss_sequencer_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  // miss request from the cache
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wren,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic                  victim_dirty,
  input  logic [TAG_W-1:0]      victim_tag,
  input  logic [DATA_W-1:0]     victim_data,
  // main memory
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_wren,
  input  logic [DATA_W-1:0]     mem_rdata,
  // refill to the cache
  output logic                  fill_valid,
  output logic [DATA_W-1:0]     fill_data,
  output logic [IDX_W-1:0]      fill_index,
  output logic [TAG_W-1:0]      fill_tag,
  // status
  output logic                  done,
  output logic                  busy,
  output logic [CNT_W-1:0]      wb_count,
  output logic [CNT_W-1:0]      fill_count,
  // debug view of the FSM and captured request
  output miss_dbg_t             dbg
);

  // Reload value of the read-latency down-counter
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

  state_e               state;
  state_e               next_state;

  // Request captured on the accepting edge
  logic [ADDR_W-1:0]    addr_q;
  logic                 wren_q;
  logic                 dirty_q;
  logic [TAG_W-1:0]     vtag_q;
  logic [DATA_W-1:0]    vdata_q;

  logic [LAT_W-1:0]     lat_cnt;
  logic [DATA_W-1:0]    rdata_q;

  logic                 accept;
  logic                 rd_exit;
  logic                 enter_rd;

  assign accept   = (state == S_IDLE) && req_valid;
  assign rd_exit  = (state == S_RD) && (lat_cnt == '0);
  assign enter_rd = (state != S_RD) && (next_state == S_RD);

  // Next-state selection for the miss FSM
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (victim_dirty)   next_state = S_WB;
          else if (!req_wren) next_state = S_RD;
          else                next_state = S_DONE;
        end
      end
      S_WB:    next_state = wren_q ? S_DONE : S_RD;
      S_RD:    next_state = (lat_cnt == '0) ? S_FILL : S_RD;
      S_FILL:  next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // State register; reset abandons any miss in progress
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Capture the request and victim on the accepting edge only
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q  <= '0;
      wren_q  <= 1'b0;
      dirty_q <= 1'b0;
      vtag_q  <= '0;
      vdata_q <= '0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wren_q  <= req_wren;
      dirty_q <= victim_dirty;
      vtag_q  <= victim_tag;
      vdata_q <= victim_data;
    end
  end

  // Memory read latency: load on RD entry, count down while in RD
  always_ff @(posedge clock) begin
    if (reset) begin
      lat_cnt <= '0;
    end else if (enter_rd) begin
      lat_cnt <= LAT_LOAD;
    end else if ((state == S_RD) && (lat_cnt != '0)) begin
      lat_cnt <= lat_cnt - 1'b1;
    end
  end

  // Hold the memory read data sampled on the edge leaving RD
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (rd_exit) begin
      rdata_q <= mem_rdata;
    end
  end

  // Memory port: writes only in WB, read address only in RD, zero elsewhere
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    case (state)
      S_WB: begin
        mem_wren  = 1'b1;
        mem_addr  = {vtag_q[MEM_ADDR_W-IDX_W-1:0], addr_index(addr_q)};
        mem_wdata = vdata_q;
      end
      S_RD: begin
        mem_addr  = addr_q[MEM_ADDR_W-1:0];
      end
      default: begin
        mem_addr  = '0;
      end
    endcase
  end

  // Refill strobe and completion strobe, zero outside their states
  always_comb begin
    fill_valid = 1'b0;
    fill_data  = '0;
    fill_index = '0;
    fill_tag   = '0;
    done       = 1'b0;
    if (state == S_FILL) begin
      fill_valid = 1'b1;
      fill_data  = rdata_q;
      fill_index = addr_index(addr_q);
      fill_tag   = addr_tag(addr_q);
    end
    if (state == S_DONE) begin
      done = 1'b1;
    end
  end

  assign req_ready = (state == S_IDLE);
  assign busy      = ~req_ready;

  // Debug snapshot of the FSM and the captured request
  always_comb begin
    dbg            = '0;
    dbg.state      = state;
    dbg.wren       = wren_q;
    dbg.dirty      = dirty_q;
    dbg.victim_tag = vtag_q;
    dbg.addr       = addr_q;
  end

  // One increment per writeback cycle; reset clears and suppresses it
  sat_counter #(.WIDTH(CNT_W)) u_wb_count (
    .clock (clock),
    .clear (reset),
    .inc   (state == S_WB),
    .count (wb_count)
  );

  // One increment per refill cycle; reset clears and suppresses it
  sat_counter #(.WIDTH(CNT_W)) u_fill_count (
    .clock (clock),
    .clear (reset),
    .inc   (state == S_FILL),
    .count (fill_count)
  );

endmodule
